cluster_input_packer: RTL and testbench

//  Writer side of the cluster evaluation interface. Assembles the flat IN_W-bit input

---
 rtl/cluster_io_pkg.sv | 21 ++
 rtl/cluster_chunk_demux.sv | 35 +++
 rtl/cluster_input_packer.sv | 138 +++++++++++++
 tb/tb_cluster_input_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_io_pkg.sv
// Shared defaults, chunk-count helper and FSM state encoding for the
// cluster evaluation interface.
package cluster_io_pkg;

    localparam int IN_W_DEF       = 1894;
    localparam int OUT_W_DEF      = 128;
    localparam int CHUNK_W_DEF    = 32;
    localparam int SETTLE_CYC_DEF = 2;

    // Number of stream words needed to cover an in_w-bit vector.
    function automatic int nchunk(input int in_w, input int chunk_w);
        return (in_w + chunk_w - 1) / chunk_w;
    endfunction

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/cluster_chunk_demux.sv
// Turns the current chunk index and beat strobe into a bit-level write mask
// and aligned write data for the packed input vector. Bits of the final
// chunk that fall beyond IN_W are dropped here.
module cluster_chunk_demux
    import cluster_io_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF,
    parameter int NCHUNK  = nchunk(IN_W, CHUNK_W),
    parameter int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
)(
    input  logic               beat,
    input  logic [IDX_W-1:0]   idx,
    input  logic [CHUNK_W-1:0] s_data,
    output logic [IN_W-1:0]    wr_mask,
    output logic [IN_W-1:0]    wr_data
);

    for (genvar n = 0; n < NCHUNK; n++) begin : g_slice
        localparam int LO = n * CHUNK_W;
        localparam int W  = (IN_W - LO < CHUNK_W) ? (IN_W - LO) : CHUNK_W;

        logic we;
        assign we              = beat && (idx == IDX_W'(n));
        assign wr_mask[LO +: W] = {W{we}};
        assign wr_data[LO +: W] = we ? s_data[W-1:0] : '0;

        // Upper bits of the last word have no home in i_vec.
        if (W < CHUNK_W) begin : g_tail
            logic tail_unused;
            assign tail_unused = ^s_data[CHUNK_W-1:W];
        end
    end

endmodule

// File: rtl/cluster_input_packer.sv
// Writer side of the cluster evaluation interface: packs a framed word
// stream into i_vec, holds it while the external cones settle, then
// returns the captured o_vec on a valid/ready result port.
module cluster_input_packer
    import cluster_io_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int CHUNK_W    = CHUNK_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHUNK_W-1:0] s_data,
    input  logic               s_last,
    output logic [IN_W-1:0]    i_vec,
    input  logic [OUT_W-1:0]   o_vec,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [OUT_W-1:0]   m_data,
    output logic               err
);

    localparam int NCHUNK = nchunk(IN_W, CHUNK_W);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_e             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               m_valid_n;
    logic [OUT_W-1:0]   m_data_n;
    logic               err_n;
    logic               rst_q;
    logic               beat;
    logic [IN_W-1:0]    wr_mask, wr_data;

    // Reset release is taken on the first clock after rst_n rises; until then
    // the stream side stays closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 1'b0;
        else        rst_q <= 1'b1;
    end

    // Ready depends only on registered state, never on s_valid.
    assign s_ready = rst_q && (state == ST_LOAD);
    assign beat    = s_valid && s_ready;

    cluster_chunk_demux #(
        .IN_W    (IN_W),
        .CHUNK_W (CHUNK_W),
        .NCHUNK  (NCHUNK),
        .IDX_W   (IDX_W)
    ) u_demux (
        .beat    (beat),
        .idx     (idx),
        .s_data  (s_data),
        .wr_mask (wr_mask),
        .wr_data (wr_data)
    );

    // Input vector: only the addressed slice changes; everything else,
    // including partial contents after a length error, is retained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) i_vec <= '0;
        else        i_vec <= (i_vec & ~wr_mask) | wr_data;
    end

    // FSM and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_LOAD;
            idx     <= '0;
            cnt     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            err     <= err_n;
        end
    end

    // Next-state: frame length checking in LOAD, settle countdown, result hold.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        m_valid_n = m_valid;
        m_data_n  = m_data;
        err_n     = 1'b0;
        case (state)
            ST_LOAD: begin
                if (beat) begin
                    if (idx == IDX_LAST) begin
                        idx_n = '0;
                        if (s_last) begin
                            state_n = ST_SETTLE;
                            cnt_n   = CNT_W'(SETTLE_CYC - 1);
                        end else begin
                            err_n = 1'b1;              // long frame
                        end
                    end else if (s_last) begin
                        idx_n = '0;
                        err_n = 1'b1;                  // short frame
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    m_data_n  = o_vec;
                    m_valid_n = 1'b1;
                    state_n   = ST_RESULT;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    idx_n     = '0;
                    state_n   = ST_LOAD;
                end
            end
            default: state_n = ST_LOAD;
        endcase
    end

endmodule

// File: tb/tb_cluster_input_packer.sv
// Directed bench for cluster_input_packer with a small XOR cone model.
module tb_cluster_input_packer;

    localparam int IN_W    = 1894;
    localparam int OUT_W   = 128;
    localparam int CHUNK_W = 32;
    localparam int NCHUNK  = 60;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [CHUNK_W-1:0] s_data = '0;
    logic               s_last = 1'b0;
    logic [IN_W-1:0]    i_vec;
    logic [OUT_W-1:0]   o_vec;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [OUT_W-1:0]   m_data;
    logic               err;

    int n_cmp = 0;
    int n_bad = 0;
    int bidx  = 0;
    logic [IN_W-1:0] exp_vec = '0;

    always #5 clk = ~clk;

    // Stand-in for the cluster's combinational output cones.
    function automatic logic [OUT_W-1:0] cone(input logic [IN_W-1:0] v);
        return v[OUT_W-1:0] ^ v[IN_W-1 -: OUT_W] ^ {v[900 +: 64], v[1500 +: 64]};
    endfunction

    assign o_vec = cone(i_vec);

    cluster_input_packer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .i_vec   (i_vec),
        .o_vec   (o_vec),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err     (err)
    );

    // Drive one word, wait (bounded) for acceptance, update the reference vector.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int w;
        s_valid = 1'b1; s_data = d; s_last = last;
        w = 0;
        while (!s_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_timeout s_ready=%0b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < CHUNK_W; k++)
            if (bidx * CHUNK_W + k < IN_W) exp_vec[bidx * CHUNK_W + k] = d[k];
        bidx = (last || bidx == NCHUNK - 1) ? 0 : bidx + 1;
    endtask

    // mode 0: data=n; 1: random data; 2: random data with ~50% idle cycles.
    task automatic send_frame(input int mode);
        for (int n = 0; n < NCHUNK; n++) begin
            if (mode == 2 && $urandom_range(1, 0) == 1) begin
                s_valid = 1'b0; @(posedge clk); #1;
            end
            send_beat((mode == 0) ? 32'(n) : $urandom, n == NCHUNK - 1);
        end
    endtask

    // Called just after the final beat; lat counts cycles with the beat cycle as 0.
    task automatic wait_mv(output int lat);
        lat = 1;
        while (!m_valid && lat < 300) begin @(posedge clk); #1; lat++; end
        if (!m_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout m_valid=%0b required 1", m_valid);
        end
    endtask

    task automatic release_reset();
        @(negedge clk); rst_n = 1'b1;
        exp_vec = '0; bidx = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #23;
        n_cmp++; if (i_vec !== '0) begin n_bad++; $display("FAIL rst_i_vec got nonzero required 0"); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %0b required 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL rst_m_data got %h required 0", m_data); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b required 0", err); end
        release_reset();
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready got %0b required 1", s_ready); end
    endtask

    task automatic test_full_frame();
        int lat;
        m_ready = 1'b0;
        send_frame(0);
        wait_mv(lat);
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL frame_latency got %0d required 3", lat); end
        n_cmp++; if (i_vec[31:0] !== 32'd0) begin n_bad++; $display("FAIL frame_slice0 got %h required 0", i_vec[31:0]); end
        n_cmp++; if (i_vec[1893:1888] !== 6'd59) begin n_bad++; $display("FAIL frame_tail got %0d required 59", i_vec[1893:1888]); end
        n_cmp++; if (i_vec !== exp_vec) begin n_bad++; $display("FAIL frame_i_vec got differs from reference"); end
        n_cmp++; if (m_data !== cone(exp_vec)) begin n_bad++; $display("FAIL frame_m_data got %h required %h", m_data, cone(exp_vec)); end
        m_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL frame_mv_drop got %0b required 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL frame_s_ready got %0b required 1", s_ready); end
    endtask

    task automatic test_short_frame();
        int lat, mv_seen;
        m_ready = 1'b1;
        for (int n = 0; n <= 10; n++) send_beat($urandom, n == 10);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL short_err got %0b required 1", err); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL short_err_pulse got %0b required 0", err); end
        mv_seen = 0;
        for (int c = 0; c < 6; c++) begin if (m_valid) mv_seen++; @(posedge clk); #1; end
        n_cmp++; if (mv_seen != 0) begin n_bad++; $display("FAIL short_no_result got %0d required 0", mv_seen); end
        send_frame(1);
        wait_mv(lat);
        n_cmp++; if (m_data !== cone(exp_vec)) begin n_bad++; $display("FAIL short_next_m_data got %h required %h", m_data, cone(exp_vec)); end
        @(posedge clk); #1;
    endtask

    task automatic test_long_frame();
        int lat, mv_seen;
        m_ready = 1'b1;
        for (int n = 0; n < NCHUNK; n++) send_beat($urandom, 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL long_err got %0b required 1", err); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL long_s_ready got %0b required 1", s_ready); end
        mv_seen = 0;
        for (int c = 0; c < 6; c++) begin if (m_valid) mv_seen++; @(posedge clk); #1; end
        n_cmp++; if (mv_seen != 0) begin n_bad++; $display("FAIL long_no_result got %0d required 0", mv_seen); end
        send_frame(1);
        wait_mv(lat);
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL long_next_latency got %0d required 3", lat); end
        n_cmp++; if (m_data !== cone(exp_vec)) begin n_bad++; $display("FAIL long_next_m_data got %h required %h", m_data, cone(exp_vec)); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat, bad_cyc;
        logic [OUT_W-1:0] want;
        m_ready = 1'b0;
        send_frame(1);
        wait_mv(lat);
        want = cone(exp_vec);
        bad_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid !== 1'b1 || m_data !== want || s_ready !== 1'b0) bad_cyc++;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad_cyc != 0) begin n_bad++; $display("FAIL hold_stable got %0d bad cycles required 0", bad_cyc); end
        m_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL hold_mv_drop got %0b required 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL hold_s_ready got %0b required 1", s_ready); end
    endtask

    task automatic test_random();
        int lat;
        m_ready = 1'b1;
        for (int f = 0; f < 150; f++) begin
            send_frame(2);
            wait_mv(lat);
            n_cmp++;
            if (m_data !== cone(exp_vec) || i_vec !== exp_vec) begin
                n_bad++;
                $display("FAIL rand_frame %0d m_data got %h required %h", f, m_data, cone(exp_vec));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        m_ready = 1'b1;
        for (int n = 0; n < 30; n++) send_beat(32'(n + 1), 1'b0);
        s_valid = 1'b1; s_data = 32'hdead_beef; #2;
        rst_n = 1'b0; #1;
        s_valid = 1'b0;
        n_cmp++; if (i_vec !== '0) begin n_bad++; $display("FAIL midload_i_vec got nonzero required 0"); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL midload_s_ready got %0b required 0", s_ready); end
        release_reset();
        send_frame(1);
        wait_mv(lat);
        n_cmp++; if (m_data !== cone(exp_vec)) begin n_bad++; $display("FAIL midload_next got %h required %h", m_data, cone(exp_vec)); end
        @(posedge clk); #1;
        m_ready = 1'b0;
        send_frame(1);
        wait_mv(lat);
        #2; rst_n = 1'b0; #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midres_m_valid got %0b required 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL midres_m_data got %h required 0", m_data); end
        n_cmp++; if (i_vec !== '0) begin n_bad++; $display("FAIL midres_i_vec got nonzero required 0"); end
        release_reset();
        m_ready = 1'b1;
        send_frame(1);
        wait_mv(lat);
        n_cmp++; if (m_data !== cone(exp_vec)) begin n_bad++; $display("FAIL midres_next got %h required %h", m_data, cone(exp_vec)); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_long_frame();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
